mems_marker_fifo_writer: RTL and testbench

Downstream consumer of the MEMS line/frame event generator. It converts the level-held new_line / new_frame requests into tagged marker words and writes them into the acquisition FIFO. It returns a one-cycle new_line_FIFO_done / new_frame_FIFO_done acknowledge to the generator. It tracks line-within-frame and frame indices, and drops markers after a bounded FIFO-full stall so the upstream generator can never hang.

---
 rtl/mems_marker_fifo_writer.sv | 113 +++++++++++
 tb/tb_mems_marker_fifo_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mems_marker_fifo_writer.sv
// Turns level-held line/frame requests into tagged FIFO marker words, acknowledges them upstream,
// and drops a marker after a bounded FIFO-full stall so the event generator can never hang.
module mems_marker_fifo_writer #(
    parameter int DATA_W    = 16,
    parameter int MAX_STALL = 1024,
    parameter int DROP_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_line,
    input  logic              new_frame,
    input  logic              fifo_full,
    output logic              new_line_FIFO_done,
    output logic              new_frame_FIFO_done,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic [DATA_W-3:0] line_idx,
    output logic [DATA_W-3:0] frame_idx,
    output logic [DROP_W-1:0] drop_count
);

    localparam int IDX_W   = DATA_W - 2;
    localparam int STALL_W = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_FRAME,
        WR_LINE,
        ACK_FRAME,
        ACK_LINE,
        REL_FRAME,
        REL_LINE
    } state_t;

    state_t              r_state;
    logic [STALL_W-1:0]  r_stall;
    logic [DATA_W-1:0]   r_din;
    logic [IDX_W-1:0]    r_line;
    logic [IDX_W-1:0]    r_frame;
    logic [DROP_W-1:0]   r_drop;

    logic w_in_wr;
    logic w_wr;
    logic w_timeout;
    logic w_advance;

    assign w_in_wr   = (r_state == WR_FRAME) || (r_state == WR_LINE);
    assign w_wr      = w_in_wr && !fifo_full;
    assign w_timeout = w_in_wr && fifo_full && (r_stall == STALL_LIMIT);
    assign w_advance = w_wr || w_timeout;

    assign fifo_wr_en          = w_wr;
    assign new_frame_FIFO_done = (r_state == ACK_FRAME);
    assign new_line_FIFO_done  = (r_state == ACK_LINE);
    assign fifo_din            = r_din;
    assign line_idx            = r_line;
    assign frame_idx           = r_frame;
    assign drop_count          = r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_stall <= '0;
            r_din   <= '0;
            r_line  <= '0;
            r_frame <= '0;
            r_drop  <= '0;
        end else begin
            // A dropped marker advances the indices too, so downstream sees the gap.
            if (w_timeout && (r_drop != '1))
                r_drop <= r_drop + DROP_W'(1);

            case (r_state)
                IDLE: begin
                    if (new_frame) begin
                        r_state <= WR_FRAME;
                        r_din   <= {2'b10, r_frame};
                    end else if (new_line) begin
                        r_state <= WR_LINE;
                        r_din   <= {2'b01, r_line};
                    end
                end
                WR_FRAME: begin
                    if (w_advance) begin
                        r_state <= ACK_FRAME;
                        r_stall <= '0;
                        r_frame <= r_frame + IDX_W'(1);
                        r_line  <= '0;
                    end else begin
                        r_stall <= r_stall + STALL_W'(1);
                    end
                end
                WR_LINE: begin
                    if (w_advance) begin
                        r_state <= ACK_LINE;
                        r_stall <= '0;
                        r_line  <= r_line + IDX_W'(1);
                    end else begin
                        r_stall <= r_stall + STALL_W'(1);
                    end
                end
                ACK_FRAME: r_state <= REL_FRAME;
                ACK_LINE:  r_state <= REL_LINE;
                // Hold here until the stale request drops, so it is never serviced twice.
                REL_FRAME: if (!new_frame) r_state <= IDLE;
                REL_LINE:  if (!new_line)  r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mems_marker_fifo_writer.sv
// Self-checking bench: two writer instances (16-bit word and 6-bit word), expected
// marker words queued when requests are driven and compared as the FIFO writes appear.
module tb_mems_marker_fifo_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=16, MAX_STALL=8
    logic        rstA, lineA, frameA, fullA;
    logic        lineDoneA, frameDoneA, wrA;
    logic [15:0] dinA;
    logic [13:0] lineIdxA, frameIdxA;
    logic [15:0] dropA;

    // Instance B: DATA_W=6, MAX_STALL=4
    logic        rstB, lineB, frameB, fullB;
    logic        lineDoneB, frameDoneB, wrB;
    logic [5:0]  dinB;
    logic [3:0]  lineIdxB, frameIdxB;
    logic [15:0] dropB;

    mems_marker_fifo_writer #(.DATA_W(16), .MAX_STALL(8), .DROP_W(16)) dutA (
        .clk(clk), .rst(rstA), .new_line(lineA), .new_frame(frameA), .fifo_full(fullA),
        .new_line_FIFO_done(lineDoneA), .new_frame_FIFO_done(frameDoneA),
        .fifo_wr_en(wrA), .fifo_din(dinA), .line_idx(lineIdxA), .frame_idx(frameIdxA),
        .drop_count(dropA)
    );

    mems_marker_fifo_writer #(.DATA_W(6), .MAX_STALL(4), .DROP_W(16)) dutB (
        .clk(clk), .rst(rstB), .new_line(lineB), .new_frame(frameB), .fifo_full(fullB),
        .new_line_FIFO_done(lineDoneB), .new_frame_FIFO_done(frameDoneB),
        .fifo_wr_en(wrB), .fifo_din(dinB), .line_idx(lineIdxB), .frame_idx(frameIdxB),
        .drop_count(dropB)
    );

    int vectorsApplied = 0;
    int miscompares    = 0;

    logic [15:0] qA[$];
    logic [5:0]  qB[$];
    logic [13:0] modelLineA  = '0;
    logic [13:0] modelFrameA = '0;
    logic [15:0] modelDropA  = '0;
    logic [3:0]  modelLineB  = '0;

    // Single comparison point: counts every check and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Scoreboard: every FIFO write must match the oldest queued marker, never while full,
    // and the two acknowledges must never coincide.
    always @(negedge clk) begin
        if (!rstA) begin
            if (wrA) begin
                if (qA.size() == 0) checkOutput("unexpectedWriteA", 32'(dinA), 32'hFFFF_FFFF);
                else checkOutput("fifoDinA", 32'(dinA), 32'(qA.pop_front()));
                checkOutput("writeWhileFullA", 32'(fullA), 32'd0);
            end
            if (lineDoneA && frameDoneA) checkOutput("doneOverlapA", 32'd1, 32'd0);
        end
        if (!rstB && wrB) begin
            if (qB.size() == 0) checkOutput("unexpectedWriteB", 32'(dinB), 32'hFFFF_FFFF);
            else checkOutput("fifoDinB", 32'(dinB), 32'(qB.pop_front()));
            checkOutput("writeWhileFullB", 32'(fullB), 32'd0);
        end
    end

    // Bounded wait for the acknowledge matching the request; returns cycles waited.
    task automatic waitDone(input bit onB, input bit isFrame, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (onB) seen = lineDoneB;
            else     seen = isFrame ? frameDoneA : lineDoneA;
        end
        checkOutput(isFrame ? "frameDoneSeen" : "lineDoneSeen", 32'(seen), 32'd1);
    endtask

    // Upstream clears the request the cycle after seeing done; writer returns to IDLE next edge.
    task automatic finishReq(input bit onB, input bit isFrame);
        @(posedge clk); #1;
        if (onB)          lineB  = 1'b0;
        else if (isFrame) frameA = 1'b0;
        else              lineA  = 1'b0;
        @(posedge clk);
    endtask

    task automatic applyStimulus(input bit onB, input bit isFrame);
        int cycles;
        @(posedge clk); #1;
        if (onB) begin
            qB.push_back({2'b01, modelLineB});
            modelLineB++;
            lineB = 1'b1;
        end else if (isFrame) begin
            qA.push_back({2'b10, modelFrameA});
            modelFrameA++;
            modelLineA = '0;
            frameA = 1'b1;
        end else begin
            qA.push_back({2'b01, modelLineA});
            modelLineA++;
            lineA = 1'b1;
        end
        waitDone(onB, isFrame, cycles);
        checkOutput("ackLatency", 32'(cycles), 32'd3);
        finishReq(onB, isFrame);
    endtask

    initial begin
        int cycles;
        rstA = 1'b1; lineA = 1'b0; frameA = 1'b0; fullA = 1'b0;
        rstB = 1'b1; lineB = 1'b0; frameB = 1'b0; fullB = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetOutputsA",
                    32'({dinA, lineIdxA, frameIdxA, dropA, wrA, lineDoneA, frameDoneA} != '0), 32'd0);
        @(posedge clk); #1 rstA = 1'b0;

        // Single line with exact cycle-by-cycle latency
        @(posedge clk); #1;
        qA.push_back({2'b01, modelLineA});
        modelLineA++;
        lineA = 1'b1;
        @(negedge clk); checkOutput("wrBeforeSample", 32'(wrA), 32'd0);
        @(negedge clk); checkOutput("wrAfterSample", 32'(wrA), 32'd1);
        @(negedge clk); checkOutput("lineDoneCycle", 32'(lineDoneA), 32'd1);
        checkOutput("wrSingleCycle", 32'(wrA), 32'd0);
        finishReq(1'b0, 1'b0);
        checkOutput("lineIdxAfterOne", 32'(lineIdxA), 32'd1);
        applyStimulus(1'b0, 1'b0);

        // Line bursts followed by a frame marker resetting the line index
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lineIdxAfterFrame", 32'(lineIdxA), 32'(modelLineA));
        checkOutput("frameIdxAfterFrame", 32'(frameIdxA), 32'(modelFrameA));
        applyStimulus(1'b0, 1'b0);

        // Simultaneous requests: frame first, then line with index 0
        @(posedge clk); #1;
        qA.push_back({2'b10, modelFrameA});
        modelFrameA++;
        modelLineA = '0;
        qA.push_back({2'b01, modelLineA});
        modelLineA++;
        frameA = 1'b1; lineA = 1'b1;
        waitDone(1'b0, 1'b1, cycles);
        finishReq(1'b0, 1'b1);
        waitDone(1'b0, 1'b0, cycles);
        finishReq(1'b0, 1'b0);
        checkOutput("lineIdxAfterBoth", 32'(lineIdxA), 32'(modelLineA));
        checkOutput("frameIdxAfterBoth", 32'(frameIdxA), 32'(modelFrameA));

        // Short stall: full for 5 write-state cycles, then the write goes through
        @(posedge clk); #1;
        qA.push_back({2'b01, modelLineA});
        modelLineA++;
        fullA = 1'b1; lineA = 1'b1;
        repeat (6) @(posedge clk);
        #1 fullA = 1'b0;
        waitDone(1'b0, 1'b0, cycles);
        finishReq(1'b0, 1'b0);
        checkOutput("dropAfterShortStall", 32'(dropA), 32'(modelDropA));
        checkOutput("lineIdxAfterShortStall", 32'(lineIdxA), 32'(modelLineA));

        // Long stall: marker dropped after 8 full cycles, index still advances
        @(posedge clk); #1;
        modelLineA++;
        modelDropA++;
        fullA = 1'b1; lineA = 1'b1;
        waitDone(1'b0, 1'b0, cycles);
        checkOutput("dropLatency", 32'(cycles), 32'd10);
        finishReq(1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1 fullA = 1'b0;
        checkOutput("dropCount", 32'(dropA), 32'(modelDropA));
        checkOutput("lineIdxAfterDrop", 32'(lineIdxA), 32'(modelLineA));
        applyStimulus(1'b0, 1'b0);

        // Narrow instance: line index wraps through zero
        @(posedge clk); #1 rstB = 1'b0;
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("lineIdxWrapB", 32'(lineIdxB), 32'(modelLineB));

        // Reset asserted while stalled in the line write state
        @(posedge clk); #1;
        fullB = 1'b1; lineB = 1'b1;
        repeat (2) @(posedge clk);
        #3 rstB = 1'b1;
        #1;
        checkOutput("asyncResetOutputsB",
                    32'({dinB, lineIdxB, frameIdxB, dropB, wrB, lineDoneB, frameDoneB} != '0), 32'd0);
        modelLineB = '0;
        qB.push_back({2'b01, modelLineB});
        modelLineB++;
        @(posedge clk); #1 fullB = 1'b0;
        @(posedge clk); #1 rstB = 1'b0;
        waitDone(1'b1, 1'b0, cycles);
        finishReq(1'b1, 1'b0);
        checkOutput("lineIdxAfterResetB", 32'(lineIdxB), 32'(modelLineB));

        repeat (3) @(posedge clk);
        checkOutput("pendingA", 32'(qA.size()), 32'd0);
        checkOutput("pendingB", 32'(qB.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
